// File: rtl/button_debouncer.sv
// Debounces a raw mechanical input: 2-flop synchronizer feeding a run-length
// stability FSM, plus a saturating count of aborted transitions.
module button_debouncer #(
  parameter int CNT_WIDTH     = 20,
  parameter int STABLE_CYCLES = 1000000,
  parameter int BOUNCE_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signal_in,
  output logic                    signal_out,
  output logic                    busy,
  output logic [BOUNCE_WIDTH-1:0] bounce_count,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   SINGLE   = (STABLE_CYCLES == 1);

  logic                    sync1_q, sync2_q;
  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    out_q, busy_q;
  logic [BOUNCE_WIDTH-1:0] bounce_q, bounce_d;

  // Saturating increment: holding at all-ones also covers an abort at saturation.
  always_comb begin
    bounce_d = bounce_q;
    if (bounce_q != '1) bounce_d = bounce_q + BOUNCE_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      bounce_q <= '0;
    end else begin
      sync1_q <= signal_in;
      sync2_q <= sync1_q;
      unique case (state_q)
        STABLE_LOW: begin
          cnt_q <= '0;
          if (sync2_q) begin
            if (SINGLE) begin
              state_q <= STABLE_HIGH;
              out_q   <= 1'b1;
            end else begin
              state_q <= WAIT_HIGH;
              cnt_q   <= CNT_ONE;
              busy_q  <= 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          if (!sync2_q) begin
            state_q  <= STABLE_LOW;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            bounce_q <= bounce_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          cnt_q <= '0;
          if (!sync2_q) begin
            if (SINGLE) begin
              state_q <= STABLE_LOW;
              out_q   <= 1'b0;
            end else begin
              state_q <= WAIT_LOW;
              cnt_q   <= CNT_ONE;
              busy_q  <= 1'b1;
            end
          end
        end
        WAIT_LOW: begin
          if (sync2_q) begin
            state_q  <= STABLE_HIGH;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            bounce_q <= bounce_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= STABLE_LOW;
      endcase
    end
  end

  assign signal_out   = out_q;
  assign busy         = busy_q;
  assign bounce_count = bounce_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw, asynchronous mechanical input (push-button or limit switch) into a clean, synchronous level.
- Sits directly upstream of the rising-edge detector stage, which converts the clean level into a one-cycle pulse.
- Comprises a 2-flop synchronizer and a 4-state stability FSM with a run-length counter.
- Also keeps a saturating count of rejected bounces, for board bring-up diagnostics.

Parameters:
- CNT_WIDTH, 20, width of the stability counter; must satisfy 2^CNT_WIDTH > STABLE_CYCLES.
- STABLE_CYCLES, 1000000, number of consecutive synchronized samples at the new level required before signal_out changes; legal range 1 to 2^CNT_WIDTH-1.
- BOUNCE_WIDTH, 8, width of the bounce_count diagnostic counter.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- signal_in  input  1  raw asynchronous input; may bounce.
- signal_out  output  1  debounced, synchronous level; registered.
- busy  output  1  high while the FSM is in WAIT_HIGH or WAIT_LOW (candidate transition in progress).
- bounce_count  output  BOUNCE_WIDTH  number of aborted transitions; saturates at all-ones.

Behaviour:
- Synchronizer:
  - sync1 <= signal_in; sync2 <= sync1. Both reset to 0.
  - The FSM samples only sync2, referred to below as "s".
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. Reset state is STABLE_LOW.
- Reset values: signal_out=0, busy=0, bounce_count=0, cnt=0, sync1=sync2=0.
- rst has priority over every other action. Asserting rst mid-transition abandons the transition with no bounce_count increment.
- STABLE_LOW:
  - s=0: stay; cnt=0.
  - s=1 and STABLE_CYCLES==1: go to STABLE_HIGH; signal_out=1.
  - s=1 otherwise: go to WAIT_HIGH; cnt=1.
- WAIT_HIGH:
  - s=1 and cnt==STABLE_CYCLES-1: go to STABLE_HIGH; signal_out=1; cnt=0.
  - s=1 otherwise: cnt=cnt+1.
  - s=0: go to STABLE_LOW; cnt=0; bounce_count=bounce_count+1, saturating.
- STABLE_HIGH and WAIT_LOW mirror the above with levels inverted. The WAIT_LOW to STABLE_HIGH abort also increments bounce_count.
- signal_out changes only on entry to a STABLE state. It never changes while in a WAIT state.
- busy is a registered decode of the next state: high in the cycle after entering WAIT_*, low in the cycle after leaving it.
- Latency: signal_in steady at the new level, meeting setup before edge E0, gives signal_out at the new level after edge E0+STABLE_CYCLES+1.
- Glitch rejection: any pulse (high or low) on signal_in shorter than STABLE_CYCLES cycles never reaches signal_out.
- bounce_count:
  - Wraps never; holds at 2^BOUNCE_WIDTH-1.
  - A simultaneous abort at saturation leaves it unchanged.
- cnt never exceeds STABLE_CYCLES-1. The comparison uses equality against STABLE_CYCLES-1 at CNT_WIDTH bits.
- Output contract to the downstream edge detector:
  - signal_out is glitch-free.
  - Minimum high and low dwell of signal_out is STABLE_CYCLES cycles.

Test Plan:
- STABLE_CYCLES=4, rst held 3 cycles, then signal_in=1 steady from before edge E0 -> signal_out=0 through edge E4, =1 after E5; busy high after E2 through E4; bounce_count=0.
- STABLE_CYCLES=4, signal_out=0, signal_in pattern 1,1,0,1,1,1,1 (one value per cycle) -> first WAIT_HIGH aborted, bounce_count=1; signal_out rises 4 samples after the second run begins.
- STABLE_CYCLES=4, signal_out=1, single-cycle 0 glitches every 3 cycles for 50 cycles -> signal_out stays 1; bounce_count increments once per glitch.
- BOUNCE_WIDTH=2, 6 aborted transitions -> bounce_count reads 1,2,3,3,3,3.
- STABLE_CYCLES=4, rst asserted for 1 cycle while in WAIT_HIGH with cnt=2 -> next cycle signal_out=0, busy=0, bounce_count=0, state STABLE_LOW; clean 1 afterwards needs a full 4 samples.
- STABLE_CYCLES=1 -> signal_out follows signal_in delayed exactly 2 cycles; busy never asserts; bounce_count stays 0.
